// File: rtl/link_fork_n_if.sv
// rtl/link_fork_n_if.sv - handshake bundle for the N-way dual-rail link fork (LINK_FORK_MASK_EN adds en_mask)
interface link_fork_n_if #(
    parameter int WIDTH   = 1,
    parameter int OUT_NUM = 2
);
    localparam int RAIL_NUM = 2;

    logic                                        start;
    logic [WIDTH-1:0][RAIL_NUM-1:0]              in;
    logic                                        ack_o;
    logic [OUT_NUM-1:0]                          ack_i;
    logic [OUT_NUM-1:0][WIDTH-1:0][RAIL_NUM-1:0] out;
    logic                                        busy;
    logic                                        err;
`ifdef LINK_FORK_MASK_EN
    logic [OUT_NUM-1:0]                          en_mask;

    modport master (
        output start, in, ack_i, en_mask,
        input  ack_o, out, busy, err
    );

    modport slave (
        input  start, in, ack_i, en_mask,
        output ack_o, out, busy, err
    );
`else
    modport master (
        output start, in, ack_i,
        input  ack_o, out, busy, err
    );

    modport slave (
        input  start, in, ack_i,
        output ack_o, out, busy, err
    );
`endif
endinterface

// File: rtl/link_fork_n.sv
// rtl/link_fork_n.sv - clocked N-way dual-rail four-phase link fork with joined ack (optional LINK_FORK_MASK_EN)
module link_fork_n #(
    parameter int WIDTH   = 1,
    parameter int OUT_NUM = 2
) (
    input  logic          clk,
    input  logic          rst,
    link_fork_n_if.slave  bus
);
    localparam int RAIL_NUM = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DATA  = 2'd1,
        S_ACKED = 2'd2,
        S_RTZ   = 2'd3
    } state_t;

    state_t                                      r_state;
    state_t                                      w_state_nxt;
    logic [OUT_NUM-1:0][WIDTH-1:0][RAIL_NUM-1:0] r_out;
    logic [OUT_NUM-1:0][WIDTH-1:0][RAIL_NUM-1:0] w_out_nxt;
    logic                                        r_ack_o;
    logic                                        w_ack_nxt;
    logic                                        r_err;

    logic                                        w_in_complete;
    logic                                        w_in_null;
    logic                                        w_in_illegal;
    logic [OUT_NUM-1:0]                          w_join;
    logic                                        w_acks_hi;
    logic                                        w_acks_lo;

`ifdef LINK_FORK_MASK_EN
    logic [OUT_NUM-1:0]                          r_mask;

    // Track the live mask while idle so the value seen at capture is frozen for the whole handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask <= '0;
        end else if (r_state == S_IDLE) begin
            r_mask <= bus.en_mask;
        end
    end

    // While idle the capture decision uses the live mask; afterwards the latched copy
    assign w_join = (r_state == S_IDLE) ? bus.en_mask : r_mask;
`else
    assign w_join = {OUT_NUM{1'b1}};
`endif

    // Classify the input word: every bit valid, every bit spacer, or any bit carrying the illegal 11 code
    always_comb begin
        w_in_complete = 1'b1;
        w_in_null     = 1'b1;
        w_in_illegal  = 1'b0;
        for (int b = 0; b < WIDTH; b++) begin
            if (bus.in[b] == 2'b11) begin
                w_in_illegal = 1'b1;
            end
            if (bus.in[b] != 2'b00) begin
                w_in_null = 1'b0;
            end
            if ((bus.in[b] != 2'b01) && (bus.in[b] != 2'b10)) begin
                w_in_complete = 1'b0;
            end
        end
    end

    // Non-participating channels count as agreeing in both directions, so an empty join is always satisfied
    assign w_acks_hi = &(bus.ack_i | ~w_join);
    assign w_acks_lo = ~|(bus.ack_i & w_join);

    // Handshake sequencing: capture, wait for all acks, wait for spacer, wait for acks to drop
    always_comb begin
        w_state_nxt = r_state;
        w_out_nxt   = r_out;
        w_ack_nxt   = r_ack_o;
        case (r_state)
            S_IDLE: begin
                if (bus.start && w_in_complete && !w_in_illegal && w_acks_lo) begin
                    w_state_nxt = S_DATA;
                    for (int c = 0; c < OUT_NUM; c++) begin
                        w_out_nxt[c] = w_join[c] ? bus.in : '0;
                    end
                end
            end
            S_DATA: begin
                if (w_acks_hi) begin
                    w_state_nxt = S_ACKED;
                    w_ack_nxt   = 1'b1;
                end
            end
            S_ACKED: begin
                if (w_in_null) begin
                    w_state_nxt = S_RTZ;
                    w_out_nxt   = '0;
                end
            end
            S_RTZ: begin
                if (w_acks_lo) begin
                    w_state_nxt = S_IDLE;
                    w_ack_nxt   = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_out_nxt   = '0;
                w_ack_nxt   = 1'b0;
            end
        endcase
    end

    // State, output and sticky error registers; reset may land mid-handshake and returns everything to idle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_out   <= '0;
            r_ack_o <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_out   <= w_out_nxt;
            r_ack_o <= w_ack_nxt;
            r_err   <= r_err | w_in_illegal;
        end
    end

    assign bus.out   = r_out;
    assign bus.ack_o = r_ack_o;
    assign bus.busy  = (r_state != S_IDLE);
    assign bus.err   = r_err;

endmodule

// File: tb/tb_link_fork_n.sv
// tb/tb_link_fork_n.sv - self-checking bench for link_fork_n (LINK_FORK_MASK_EN selects mask scenarios)
module tb_link_fork_n;
    localparam int WIDTH   = 2;
    localparam int OUT_NUM = 3;

    typedef logic [WIDTH-1:0][1:0]              chan_t;
    typedef logic [OUT_NUM-1:0][WIDTH-1:0][1:0] bcast_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    link_fork_n_if #(.WIDTH(WIDTH), .OUT_NUM(OUT_NUM)) bus ();

    link_fork_n #(.WIDTH(WIDTH), .OUT_NUM(OUT_NUM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    function automatic chan_t dr(input logic [WIDTH-1:0] v);
        chan_t r;
        for (int b = 0; b < WIDTH; b++) r[b] = v[b] ? 2'b10 : 2'b01;
        return r;
    endfunction

    function automatic bcast_t fan(input logic [WIDTH-1:0] v, input logic [OUT_NUM-1:0] m);
        bcast_t r;
        for (int c = 0; c < OUT_NUM; c++) r[c] = m[c] ? dr(v) : chan_t'(0);
        return r;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.in    = '0;
        bus.ack_i = '0;
`ifdef LINK_FORK_MASK_EN
        bus.en_mask = '1;
`endif
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++;
        if (bus.out !== '0 || bus.ack_o !== 1'b0 || bus.busy !== 1'b0 || bus.err !== 1'b0) begin
            failures++;
            $display("FAIL reset out=%h ack_o=%b busy=%b err=%b required 0/0/0/0", bus.out, bus.ack_o, bus.busy, bus.err);
        end
    endtask

    task automatic test_basic();
        bus.start = 1'b1; bus.in = dr(2'b10); bus.ack_i = '0;
        step();
        checks++;
        if (bus.out !== fan(2'b10, '1) || bus.busy !== 1'b1 || bus.ack_o !== 1'b0) begin
            failures++;
            $display("FAIL basic_capture out=%h busy=%b ack_o=%b required %h/1/0", bus.out, bus.busy, bus.ack_o, fan(2'b10, '1));
        end
        bus.ack_i = 3'b111;
        step();
        checks++;
        if (bus.ack_o !== 1'b1) begin
            failures++;
            $display("FAIL basic_ack ack_o=%b required 1", bus.ack_o);
        end
        bus.in = '0;
        step();
        checks++;
        if (bus.out !== '0 || bus.ack_o !== 1'b1) begin
            failures++;
            $display("FAIL basic_null out=%h ack_o=%b required 0/1", bus.out, bus.ack_o);
        end
        bus.ack_i = '0;
        step();
        checks++;
        if (bus.ack_o !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_rtz ack_o=%b busy=%b required 0/0", bus.ack_o, bus.busy);
        end
    endtask

    task automatic test_staggered();
        logic [OUT_NUM-1:0] rise [3];
        logic [OUT_NUM-1:0] fall [3];
        rise[0] = 3'b001; rise[1] = 3'b011; rise[2] = 3'b111;
        fall[0] = 3'b110; fall[1] = 3'b100; fall[2] = 3'b000;
        bus.start = 1'b1; bus.in = dr(2'b01); bus.ack_i = '0;
        step();
        for (int i = 0; i < 3; i++) begin
            bus.ack_i = rise[i];
            step();
            checks++;
            if (bus.ack_o !== (i == 2)) begin
                failures++;
                $display("FAIL stagger_rise ack_i=%b ack_o=%b required %b", rise[i], bus.ack_o, (i == 2));
            end
        end
        bus.in = '0;
        step();
        for (int i = 0; i < 3; i++) begin
            bus.ack_i = fall[i];
            step();
            checks++;
            if (bus.ack_o !== (i != 2) || bus.busy !== (i != 2)) begin
                failures++;
                $display("FAIL stagger_fall ack_i=%b ack_o=%b busy=%b required %b", fall[i], bus.ack_o, bus.busy, (i != 2));
            end
        end
    endtask

    task automatic test_illegal();
        bus.start = 1'b1; bus.in = {2'b11, 2'b01}; bus.ack_i = '0;
        step();
        checks++;
        if (bus.out !== '0 || bus.busy !== 1'b0 || bus.err !== 1'b1) begin
            failures++;
            $display("FAIL illegal_block out=%h busy=%b err=%b required 0/0/1", bus.out, bus.busy, bus.err);
        end
        bus.start = 1'b0; bus.in = dr(2'b01);
        step();
        checks++;
        if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL illegal_sticky err=%b busy=%b required 1/0", bus.err, bus.busy);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.in = '0;
        checks++;
        if (bus.err !== 1'b0) begin
            failures++;
            $display("FAIL illegal_clear err=%b required 0", bus.err);
        end
    endtask

    task automatic test_start_gating();
        bus.start = 1'b0; bus.in = dr(2'b11); bus.ack_i = '0;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (bus.busy !== 1'b0 || bus.out !== '0) begin
                failures++;
                $display("FAIL start_gate cyc=%0d busy=%b out=%h required 0/0", i, bus.busy, bus.out);
            end
        end
        bus.start = 1'b1;
        step();
        checks++;
        if (bus.out !== fan(2'b11, '1) || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL start_capture out=%h busy=%b required %h/1", bus.out, bus.busy, fan(2'b11, '1));
        end
        bus.start = 1'b0; bus.ack_i = '1;
        step();
        bus.in = '0;
        step();
        bus.ack_i = '0;
        step();
        checks++;
        if (bus.ack_o !== 1'b0 || bus.busy !== 1'b0 || bus.out !== '0) begin
            failures++;
            $display("FAIL start_drop_complete ack_o=%b busy=%b out=%h required 0/0/0", bus.ack_o, bus.busy, bus.out);
        end
    endtask

    task automatic test_reset_mid();
        bus.start = 1'b1; bus.in = dr(2'b10); bus.ack_i = '0;
        step();
        bus.ack_i = '1;
        step();
        rst = 1'b1;
        step();
        checks++;
        if (bus.out !== '0 || bus.ack_o !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid out=%h ack_o=%b busy=%b required 0/0/0", bus.out, bus.ack_o, bus.busy);
        end
        rst = 1'b0; bus.ack_i = '0; bus.in = dr(2'b01);
        step();
        checks++;
        if (bus.out !== fan(2'b01, '1) || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_recapture out=%h busy=%b required %h/1", bus.out, bus.busy, fan(2'b01, '1));
        end
        bus.ack_i = '1;
        step();
        bus.in = '0;
        step();
        bus.ack_i = '0;
        step();
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_finish busy=%b required 0", bus.busy);
        end
    endtask

`ifdef LINK_FORK_MASK_EN
    task automatic test_mask();
        bus.en_mask = 3'b101; bus.start = 1'b1; bus.in = dr(2'b10); bus.ack_i = '0;
        step();
        checks++;
        if (bus.out !== fan(2'b10, 3'b101) || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL mask_capture out=%h busy=%b required %h/1", bus.out, bus.busy, fan(2'b10, 3'b101));
        end
        bus.en_mask = 3'b111; bus.ack_i = 3'b010;
        step();
        checks++;
        if (bus.ack_o !== 1'b0) begin
            failures++;
            $display("FAIL mask_ignore ack_o=%b required 0", bus.ack_o);
        end
        bus.ack_i = 3'b101;
        step();
        checks++;
        if (bus.ack_o !== 1'b1) begin
            failures++;
            $display("FAIL mask_join ack_o=%b required 1", bus.ack_o);
        end
        bus.in = '0;
        step();
        bus.ack_i = 3'b010;
        step();
        checks++;
        if (bus.ack_o !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL mask_rtz ack_o=%b busy=%b required 0/0", bus.ack_o, bus.busy);
        end
        bus.ack_i = '0; bus.en_mask = '0; bus.in = dr(2'b11);
        step();
        checks++;
        if (bus.out !== '0 || bus.busy !== 1'b1 || bus.ack_o !== 1'b0) begin
            failures++;
            $display("FAIL mask_empty_capture out=%h busy=%b ack_o=%b required 0/1/0", bus.out, bus.busy, bus.ack_o);
        end
        step();
        checks++;
        if (bus.ack_o !== 1'b1) begin
            failures++;
            $display("FAIL mask_empty_ack ack_o=%b required 1", bus.ack_o);
        end
        bus.in = '0;
        step();
        step();
        checks++;
        if (bus.ack_o !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL mask_empty_done ack_o=%b busy=%b required 0/0", bus.ack_o, bus.busy);
        end
        bus.en_mask = '1;
    endtask
`endif

    task automatic test_random();
        logic [WIDTH-1:0]   v;
        logic [OUT_NUM-1:0] acks;
        bcast_t             exp;
        int                 order [OUT_NUM];
        int                 j;
        int                 tmp;
        for (int t = 0; t < 20; t++) begin
            v    = WIDTH'($urandom);
            exp  = fan(v, '1);
            acks = '0;
            bus.start = 1'b1; bus.in = dr(v); bus.ack_i = acks;
            step();
            checks++;
            if (bus.out !== exp || bus.busy !== 1'b1) begin
                failures++;
                $display("FAIL rand_capture t=%0d out=%h busy=%b required %h/1", t, bus.out, bus.busy, exp);
            end
            for (int i = 0; i < OUT_NUM; i++) order[i] = i;
            for (int i = OUT_NUM - 1; i > 0; i--) begin
                j = $urandom_range(i, 0);
                tmp = order[i]; order[i] = order[j]; order[j] = tmp;
            end
            for (int i = 0; i < OUT_NUM; i++) begin
                repeat ($urandom_range(2, 0)) begin
                    bus.in    = dr(WIDTH'($urandom));
                    bus.start = 1'($urandom_range(1, 0));
                    step();
                    checks++;
                    if (bus.ack_o !== 1'b0 || bus.out !== exp) begin
                        failures++;
                        $display("FAIL rand_hold t=%0d ack_o=%b out=%h required 0/%h", t, bus.ack_o, bus.out, exp);
                    end
                end
                acks[order[i]] = 1'b1;
                bus.ack_i = acks;
                step();
                checks++;
                if (bus.ack_o !== (acks == '1) || bus.out !== exp) begin
                    failures++;
                    $display("FAIL rand_rise t=%0d acks=%b ack_o=%b out=%h required %b/%h", t, acks, bus.ack_o, bus.out, (acks == '1), exp);
                end
            end
            bus.in = '0;
            step();
            checks++;
            if (bus.out !== '0 || bus.ack_o !== 1'b1) begin
                failures++;
                $display("FAIL rand_null t=%0d out=%h ack_o=%b required 0/1", t, bus.out, bus.ack_o);
            end
            for (int i = 0; i < OUT_NUM; i++) begin
                acks[order[$urandom_range(OUT_NUM - 1, 0)]] = 1'b0;
                if (i == OUT_NUM - 1) acks = '0;
                bus.ack_i = acks;
                step();
                checks++;
                if (bus.ack_o !== (|acks) || bus.busy !== (|acks)) begin
                    failures++;
                    $display("FAIL rand_fall t=%0d acks=%b ack_o=%b busy=%b required %b", t, acks, bus.ack_o, bus.busy, (|acks));
                end
            end
            repeat ($urandom_range(2, 0)) begin
                step();
                checks++;
                if (bus.busy !== 1'b0 || bus.out !== '0) begin
                    failures++;
                    $display("FAIL rand_idle t=%0d busy=%b out=%h required 0/0", t, bus.busy, bus.out);
                end
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        step();
        test_reset();
        test_basic();
        test_staggered();
        test_illegal();
        test_start_gating();
        test_reset_mid();
`ifdef LINK_FORK_MASK_EN
        test_mask();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
